// File: rtl/lut_dac_spi_tx.sv
// SPI mode-0 transmitter for LUT samples: {CMD, left-aligned code} shifted MSB-first, with a one-deep holding register.
// Define LUT_DAC_SPI_SIGNED_EN to treat data_in_i as two's complement (MSB inverted before framing).
module lut_dac_spi_tx #(
  parameter int         DATA_WIDTH = 8,
  parameter int         DAC_WIDTH  = 12,
  parameter logic [3:0] CMD        = 4'b0011,
  parameter int         CLK_DIV    = 2
) (
  input  logic                  clk_sys_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic                  data_vld_i,
  output logic                  busy_o,
  output logic                  drop_o,
  output logic                  frame_done_o,
  output logic                  spi_csn_o,
  output logic                  spi_sclk_o,
  output logic                  spi_mosi_o
);

  localparam int FRAME_W = 4 + DAC_WIDTH;
  localparam int HALF_N  = 2 * FRAME_W;
  localparam int HW      = $clog2(HALF_N);
  localparam int TW      = $clog2(2 * CLK_DIV);

  localparam logic [TW-1:0] DIV_LD  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(2 * CLK_DIV - 1);
  localparam logic [HW-1:0] HALF_LD = HW'(HALF_N - 1);

  // ST_IDLE: waiting for a sample | ST_SHIFT: CSN low, frame on the wire | ST_GAP: CSN-high recovery
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [HW-1:0]         half_q, half_d;
  logic [FRAME_W-1:0]    shift_q, shift_d;
  logic                  sclk_q, sclk_d;
  logic                  csn_q, csn_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  pend_q, pend_d;

  logic [DATA_WIDTH-1:0]           sample_w;
  logic [DATA_WIDTH+DAC_WIDTH-1:0] ext_w;
  logic [DAC_WIDTH-1:0]            code_w;
  logic [FRAME_W-1:0]              frame_w;
  logic                            start_w;

`ifdef LUT_DAC_SPI_SIGNED_EN
  assign sample_w = hold_q ^ {1'b1, {(DATA_WIDTH-1){1'b0}}};
`else
  assign sample_w = hold_q;
`endif

  // Left-align the sample: the zero tail drops out naturally when DATA_WIDTH == DAC_WIDTH.
  assign ext_w   = {sample_w, {DAC_WIDTH{1'b0}}};
  assign code_w  = ext_w[DATA_WIDTH+DAC_WIDTH-1 -: DAC_WIDTH];
  assign frame_w = {CMD, code_w};

  assign start_w = pend_q & en_i &
                   ((state_q == ST_IDLE) | ((state_q == ST_GAP) & (tmr_q == '0)));

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    half_d  = half_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    csn_d   = csn_q;
    done_d  = 1'b0;

    case (state_q)
      ST_SHIFT: begin
        if (tmr_q == '0) begin
          tmr_d  = DIV_LD;
          sclk_d = ~sclk_q;
          if (sclk_q) shift_d = shift_q << 1;
          if (half_q == '0) begin
            state_d = ST_GAP;
            csn_d   = 1'b1;
            done_d  = 1'b1;
            tmr_d   = GAP_LD;
          end else begin
            half_d = half_q - 1'b1;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else if (!start_w) begin
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase

    if (start_w) begin
      state_d = ST_SHIFT;
      csn_d   = 1'b0;
      sclk_d  = 1'b0;
      shift_d = frame_w;
      tmr_d   = DIV_LD;
      half_d  = HALF_LD;
    end
  end

  // A strobe that lands while the pending sample is being consumed refills the slot without loss.
  always_comb begin
    hold_d = hold_q;
    pend_d = pend_q;
    drop_o = 1'b0;
    if (!en_i) begin
      pend_d = 1'b0;
    end else if (data_vld_i) begin
      hold_d = data_in_i;
      pend_d = 1'b1;
      drop_o = pend_q & ~start_w;
    end else if (start_w) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      half_q  <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b0;
      csn_q   <= 1'b1;
      done_q  <= 1'b0;
      hold_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      half_q  <= half_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      csn_q   <= csn_d;
      done_q  <= done_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
    end
  end

  assign busy_o       = (state_q != ST_IDLE) | pend_q;
  assign frame_done_o = done_q;
  assign spi_csn_o    = csn_q;
  assign spi_sclk_o   = sclk_q;
  assign spi_mosi_o   = shift_q[FRAME_W-1];

endmodule

// File: tb/tb_lut_dac_spi_tx.sv
// Bench for lut_dac_spi_tx: an SPI-side monitor decodes frames, compared against frames computed from the samples.
module tb_lut_dac_spi_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       vld = 1'b0;
  logic [7:0] din = 8'h00;
  logic       busy, drop, done, csn, sclk, mosi;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  lut_dac_spi_tx dut (
    .clk_sys_i   (clk),
    .rst_n_i     (rst_n),
    .en_i        (en),
    .data_in_i   (din),
    .data_vld_i  (vld),
    .busy_o      (busy),
    .drop_o      (drop),
    .frame_done_o(done),
    .spi_csn_o   (csn),
    .spi_sclk_o  (sclk),
    .spi_mosi_o  (mosi)
  );

  // SPI-side monitor, sampled on the inactive clock edge
  logic [15:0] frames[$];
  int          rises_q[$];
  int          lows_q[$];
  int          falls_q[$];
  int          csn_rise_q[$];
  int          done_q[$];
  int          drop_cnt = 0;
  logic [7:0]  drop_data = 8'h00;
  logic        drop_vld = 1'b0;
  logic        csn_p = 1'b1;
  logic        sclk_p = 1'b0;
  logic [15:0] cap = 16'h0;
  int          rises = 0;
  int          low_len = 0;

  always @(negedge clk) begin
    if (!csn && csn_p) begin
      falls_q.push_back(cyc);
      cap = 16'h0;
      rises = 0;
      low_len = 0;
    end
    if (!csn) begin
      low_len++;
      if (sclk && !sclk_p) begin
        cap = {cap[14:0], mosi};
        rises++;
      end
    end
    if (csn && !csn_p) begin
      frames.push_back(cap);
      rises_q.push_back(rises);
      lows_q.push_back(low_len);
      csn_rise_q.push_back(cyc);
    end
    if (done) done_q.push_back(cyc);
    if (drop) begin
      drop_cnt++;
      drop_data = din;
      drop_vld = vld;
    end
    csn_p = csn;
    sclk_p = sclk;
  end

  // Expected frame: command nibble 3, then the 8-bit sample left-aligned in a 12-bit code
  function automatic logic [15:0] exp_frame(input logic [7:0] s);
    int v;
    v = int'(s);
`ifdef LUT_DAC_SPI_SIGNED_EN
    v = v ^ 128;
`endif
    return 16'(3 * 4096 + v * 16);
  endfunction

  task automatic clear_mon();
    frames.delete();
    rises_q.delete();
    lows_q.delete();
    falls_q.delete();
    csn_rise_q.delete();
    done_q.delete();
    drop_cnt = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] d);
    @(posedge clk); #1;
    din = d;
    vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0 || csn !== 1'b1) && n < 2000) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s idle timeout: busy=%b csn=%b after %0d cycles, required idle", name, busy, csn, n);
    end
    tick(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    tick(10);
    checks++; if (csn !== 1'b1)  begin errors++; $display("FAIL reset_csn got %b want 1", csn); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", mosi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0 || drop !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got done=%b drop=%b want 0 0", done, drop);
    end
    rst_n = 1'b1;
    tick(2);
    strobe(8'h5A);
    tick(20);
    #2;
    checks++; if (csn !== 1'b0) begin errors++; $display("FAIL midrst_active got csn=%b want 0", csn); end
    begin
      int n0;
      n0 = done_q.size();
      rst_n = 1'b0;
      #1;
      checks++; if (csn !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0) begin
        errors++; $display("FAIL midrst_async got csn=%b sclk=%b mosi=%b want 1 0 0", csn, sclk, mosi);
      end
      tick(4);
      checks++; if (done_q.size() != n0) begin
        errors++; $display("FAIL midrst_done got %0d pulses want 0", done_q.size() - n0);
      end
    end
    rst_n = 1'b1;
    tick(3);
    clear_mon();
  endtask

  task automatic test_single();
    clear_mon();
    strobe(8'hA5);
    wait_idle("single");
    checks++; if (frames.size() != 1) begin
      errors++; $display("FAIL single_count got %0d frames want 1", frames.size());
    end else begin
      checks++; if (frames[0] !== exp_frame(8'hA5)) begin
        errors++; $display("FAIL single_frame got %h want %h", frames[0], exp_frame(8'hA5));
      end
      checks++; if (rises_q[0] != 16) begin errors++; $display("FAIL single_rises got %0d want 16", rises_q[0]); end
      checks++; if (lows_q[0] != 64)  begin errors++; $display("FAIL single_csn_low got %0d want 64", lows_q[0]); end
    end
    checks++; if (done_q.size() != 1) begin
      errors++; $display("FAIL single_done got %0d pulses want 1", done_q.size());
    end else if (csn_rise_q.size() == 1) begin
      checks++; if (done_q[0] != csn_rise_q[0]) begin
        errors++; $display("FAIL single_done_time got cycle %0d want %0d", done_q[0], csn_rise_q[0]);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    strobe(8'h01);
    tick(20);
    strobe(8'h02);
    wait_idle("b2b");
    checks++; if (frames.size() != 2) begin
      errors++; $display("FAIL b2b_count got %0d frames want 2", frames.size());
    end else begin
      checks++; if (frames[0] !== 16'h3010 && exp_frame(8'h01) == 16'h3010) begin
        errors++; $display("FAIL b2b_frame0 got %h want 3010", frames[0]);
      end
      checks++; if (frames[1] !== exp_frame(8'h02)) begin
        errors++; $display("FAIL b2b_frame1 got %h want %h", frames[1], exp_frame(8'h02));
      end
      checks++; if (falls_q[1] - falls_q[0] != 68) begin
        errors++; $display("FAIL b2b_period got %0d want 68", falls_q[1] - falls_q[0]);
      end
      checks++; if (falls_q[1] - csn_rise_q[0] != 4) begin
        errors++; $display("FAIL b2b_gap got %0d want 4", falls_q[1] - csn_rise_q[0]);
      end
    end
  endtask

  task automatic test_overflow();
    clear_mon();
    strobe(8'h10);
    tick(10);
    strobe(8'h20);
    tick(10);
    strobe(8'h30);
    wait_idle("ovf");
    checks++; if (frames.size() != 2) begin
      errors++; $display("FAIL ovf_count got %0d frames want 2", frames.size());
    end else begin
      checks++; if (frames[0] !== exp_frame(8'h10) || frames[1] !== exp_frame(8'h30)) begin
        errors++; $display("FAIL ovf_frames got %h %h want %h %h", frames[0], frames[1],
                           exp_frame(8'h10), exp_frame(8'h30));
      end
    end
    checks++; if (drop_cnt != 1) begin
      errors++; $display("FAIL ovf_drop_count got %0d want 1", drop_cnt);
    end else begin
      checks++; if (drop_vld !== 1'b1 || drop_data !== 8'h30) begin
        errors++; $display("FAIL ovf_drop_when got vld=%b data=%h want 1 30", drop_vld, drop_data);
      end
    end
  endtask

  task automatic test_enable();
    clear_mon();
    strobe(8'h44);
    tick(10);
    strobe(8'h55);
    tick(5);
    en = 1'b0;
    wait_idle("enable");
    checks++; if (frames.size() != 1) begin
      errors++; $display("FAIL en_count got %0d frames want 1", frames.size());
    end else begin
      checks++; if (frames[0] !== exp_frame(8'h44)) begin
        errors++; $display("FAIL en_frame got %h want %h", frames[0], exp_frame(8'h44));
      end
    end
    checks++; if (drop_cnt != 0) begin errors++; $display("FAIL en_drop got %0d want 0", drop_cnt); end
    strobe(8'h66);
    tick(3);
    strobe(8'h77);
    tick(80);
    checks++; if (falls_q.size() != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL en_off_ignored got falls=%0d busy=%b want 1 0", falls_q.size(), busy);
    end
    en = 1'b1;
    tick(2);
  endtask

  task automatic test_macro();
    logic [15:0] e80, e00;
`ifdef LUT_DAC_SPI_SIGNED_EN
    e80 = 16'h3000;
    e00 = 16'h3800;
`else
    e80 = 16'h3800;
    e00 = 16'h3000;
`endif
    clear_mon();
    strobe(8'h80);
    wait_idle("macro80");
    strobe(8'h00);
    wait_idle("macro00");
    checks++; if (frames.size() != 2) begin
      errors++; $display("FAIL macro_count got %0d frames want 2", frames.size());
    end else begin
      checks++; if (frames[0] !== e80) begin errors++; $display("FAIL macro_80 got %h want %h", frames[0], e80); end
      checks++; if (frames[1] !== e00) begin errors++; $display("FAIL macro_00 got %h want %h", frames[1], e00); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      logic [7:0] s;
      s = 8'($urandom_range(0, 255));
      clear_mon();
      strobe(s);
      wait_idle("rnd_single");
      checks++; if (frames.size() != 1 || frames[0] !== exp_frame(s)) begin
        errors++; $display("FAIL rnd_single sample %h got %0d frames first %h want %h", s, frames.size(),
                           (frames.size() > 0) ? frames[0] : 16'hxxxx, exp_frame(s));
      end
    end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] s1, s2;
      int d;
      s1 = 8'($urandom_range(0, 255));
      s2 = 8'($urandom_range(0, 255));
      d  = int'($urandom_range(2, 55));
      clear_mon();
      strobe(s1);
      tick(d);
      strobe(s2);
      wait_idle("rnd_pair");
      checks++; if (frames.size() != 2) begin
        errors++; $display("FAIL rnd_pair_count got %0d frames want 2", frames.size());
      end else begin
        checks++; if (frames[0] !== exp_frame(s1) || frames[1] !== exp_frame(s2)) begin
          errors++; $display("FAIL rnd_pair_frames got %h %h want %h %h", frames[0], frames[1],
                             exp_frame(s1), exp_frame(s2));
        end
        checks++; if (falls_q[1] - falls_q[0] != 68) begin
          errors++; $display("FAIL rnd_pair_period got %0d want 68", falls_q[1] - falls_q[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_enable();
    test_macro();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
